// File: rtl/sys_clk_timer_host.sv
// Avalon-MM master that configures the interval timer and services each timeout IRQ.
// Service: 5 + 2*READ_LATENCY clocks from leaving WAIT to tick_pulse; no waitrequest, one-clock accesses.
module sys_clk_timer_host #(
  parameter logic [3:0] CTRL_VALUE   = 4'h7,
  parameter int         READ_LATENCY = 1,
  parameter int         TICK_W       = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              irq,
  output logic [2:0]        address,
  output logic              chipselect,
  output logic              write_n,
  output logic [15:0]       writedata,
  input  logic [15:0]       readdata,
  output logic [TICK_W-1:0] tick_count,
  output logic              tick_pulse,
  output logic [31:0]       snapshot,
  output logic              running,
  output logic              overrun
);

  localparam int               LAT_W     = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [LAT_W-1:0] LAT_LAST  = LAT_W'(READ_LATENCY - 1);
  localparam logic [2:0]       A_STATUS  = 3'd0;
  localparam logic [2:0]       A_CONTROL = 3'd1;
  localparam logic [2:0]       A_SNAPL   = 3'd4;
  localparam logic [2:0]       A_SNAPH   = 3'd5;

  typedef enum logic [3:0] {
    S_IDLE, S_CFG, S_WAIT, S_CLR, S_SNAP, S_RDL, S_RDL_W, S_RDH, S_RDH_W, S_DONE, S_STOP
  } state_t;

  state_t           state;
  logic [LAT_W-1:0] lat_cnt;
  logic [15:0]      snap_lo;
  logic             irq_q;
  logic             irq_rise;
  logic             in_window;

  // The clock right after CLR still sees the old level while the clear propagates,
  // so only a fresh rising edge from SNAP onward counts as a missed timeout.
  assign irq_rise  = irq & ~irq_q;
  assign in_window = (state inside {S_SNAP, S_RDL, S_RDL_W, S_RDH, S_RDH_W, S_DONE});

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      address    <= '0;
      chipselect <= 1'b0;
      write_n    <= 1'b1;
      writedata  <= '0;
      tick_count <= '0;
      tick_pulse <= 1'b0;
      snapshot   <= '0;
      running    <= 1'b0;
      overrun    <= 1'b0;
      lat_cnt    <= '0;
      snap_lo    <= '0;
      irq_q      <= 1'b0;
    end else begin
      chipselect <= 1'b0;
      write_n    <= 1'b1;
      tick_pulse <= 1'b0;
      irq_q      <= irq;
      if (in_window && irq_rise) overrun <= 1'b1;

      case (state)
        S_IDLE: begin
          if (enable) begin
            state      <= S_CFG;
            chipselect <= 1'b1;
            write_n    <= 1'b0;
            address    <= A_CONTROL;
            writedata  <= {12'h000, CTRL_VALUE};
            running    <= 1'b1;
          end
        end
        S_CFG: state <= S_WAIT;
        S_WAIT: begin
          if (!enable) begin
            state      <= S_STOP;
            chipselect <= 1'b1;
            write_n    <= 1'b0;
            address    <= A_CONTROL;
            writedata  <= 16'h0008;
            running    <= 1'b0;
          end else if (irq) begin
            state      <= S_CLR;
            chipselect <= 1'b1;
            write_n    <= 1'b0;
            address    <= A_STATUS;
            writedata  <= 16'h0000;
          end
        end
        S_CLR: begin
          state      <= S_SNAP;
          chipselect <= 1'b1;
          write_n    <= 1'b0;
          address    <= A_SNAPL;
          writedata  <= 16'h0000;
        end
        S_SNAP: begin
          state      <= S_RDL;
          chipselect <= 1'b1;
          address    <= A_SNAPL;
        end
        S_RDL: begin
          state   <= S_RDL_W;
          lat_cnt <= '0;
        end
        S_RDL_W: begin
          if (lat_cnt == LAT_LAST) begin
            snap_lo    <= readdata;
            state      <= S_RDH;
            chipselect <= 1'b1;
            address    <= A_SNAPH;
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
          end
        end
        S_RDH: begin
          state   <= S_RDH_W;
          lat_cnt <= '0;
        end
        S_RDH_W: begin
          // Both halves land together so snapshot is coherent whenever tick_pulse is high.
          if (lat_cnt == LAT_LAST) begin
            snapshot   <= {readdata, snap_lo};
            tick_count <= tick_count + 1'b1;
            tick_pulse <= 1'b1;
            state      <= S_DONE;
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
          end
        end
        S_DONE:  state <= S_WAIT;
        S_STOP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sys_clk_timer_host.sv
// Bench for sys_clk_timer_host: two instances (read latency 1 and 3) against a timer slave model.
module tb_sys_clk_timer_host;
  localparam int RL_A = 1;
  localparam int RL_B = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n = 1'b0;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        en_a = 1'b0, tmo_a = 1'b0, irq_a;
  logic [2:0]  addr_a;
  logic        cs_a, wn_a, tp_a, run_a, ovr_a;
  logic [15:0] wd_a, rd_a;
  logic [31:0] tc_a, snap_a;
  logic [15:0] lo_a = 16'h0, hi_a = 16'h0;

  logic        en_b = 1'b0, tmo_b = 1'b0, irq_b;
  logic [2:0]  addr_b;
  logic        cs_b, wn_b, tp_b, run_b, ovr_b;
  logic [15:0] wd_b, rd_b;
  logic [31:0] tc_b, snap_b;
  logic [15:0] lo_b = 16'h0, hi_b = 16'h0;

  sys_clk_timer_host #(.CTRL_VALUE(4'h7), .READ_LATENCY(RL_A), .TICK_W(32)) dut_a (
    .clk(clk), .reset_n(reset_n), .enable(en_a), .irq(irq_a), .address(addr_a),
    .chipselect(cs_a), .write_n(wn_a), .writedata(wd_a), .readdata(rd_a),
    .tick_count(tc_a), .tick_pulse(tp_a), .snapshot(snap_a), .running(run_a), .overrun(ovr_a));

  sys_clk_timer_host #(.CTRL_VALUE(4'h7), .READ_LATENCY(RL_B), .TICK_W(32)) dut_b (
    .clk(clk), .reset_n(reset_n), .enable(en_b), .irq(irq_b), .address(addr_b),
    .chipselect(cs_b), .write_n(wn_b), .writedata(wd_b), .readdata(rd_b),
    .tick_count(tc_b), .tick_pulse(tp_b), .snapshot(snap_b), .running(run_b), .overrun(ovr_b));

  // Timer slave model: irq set by a timeout request, cleared by a status write;
  // read data is valid only in its latency slot, random junk otherwise.
  logic        rv_a = 1'b0;
  logic [15:0] rdat_a = 16'h0, junk_a = 16'h0;
  always @(posedge clk or negedge reset_n)
    if (!reset_n) irq_a <= 1'b0;
    else if (tmo_a) irq_a <= 1'b1;
    else if (cs_a && !wn_a && addr_a == 3'd0) irq_a <= 1'b0;
  always @(posedge clk) begin
    rv_a   <= cs_a && wn_a;
    rdat_a <= (addr_a == 3'd4) ? lo_a : hi_a;
    junk_a <= 16'($urandom);
  end
  assign rd_a = rv_a ? rdat_a : junk_a;

  logic [2:0]  rv_b = 3'b000;
  logic [15:0] rd0_b = 16'h0, rd1_b = 16'h0, rd2_b = 16'h0, junk_b = 16'h0;
  always @(posedge clk or negedge reset_n)
    if (!reset_n) irq_b <= 1'b0;
    else if (tmo_b) irq_b <= 1'b1;
    else if (cs_b && !wn_b && addr_b == 3'd0) irq_b <= 1'b0;
  always @(posedge clk) begin
    rv_b   <= {rv_b[1:0], cs_b && wn_b};
    rd0_b  <= (addr_b == 3'd4) ? lo_b : hi_b;
    rd1_b  <= rd0_b;
    rd2_b  <= rd1_b;
    junk_b <= 16'($urandom);
  end
  assign rd_b = rv_b[2] ? rd2_b : junk_b;

  function automatic logic [19:0] acc(input logic wr, input logic [2:0] a, input logic [15:0] d);
    return {wr, a, wr ? d : 16'h0000};
  endfunction

  // Bus/event monitors, sampled on the falling edge.
  logic [19:0] obs_a[$], obs_b[$];
  int          ocyc_a[$], ocyc_b[$], tcyc_a[$], tcyc_b[$], rcyc_a[$], rcyc_b[$];
  logic [31:0] tsnap_a[$], tsnap_b[$];
  logic        irq_prev_a = 1'b0, irq_prev_b = 1'b0;
  always @(negedge clk) begin
    if (cs_a === 1'b1) begin obs_a.push_back(acc(!wn_a, addr_a, wd_a)); ocyc_a.push_back(cyc); end
    if (tp_a === 1'b1) begin tcyc_a.push_back(cyc); tsnap_a.push_back(snap_a); end
    if (irq_a === 1'b1 && !irq_prev_a) rcyc_a.push_back(cyc);
    irq_prev_a = (irq_a === 1'b1);
    if (cs_b === 1'b1) begin obs_b.push_back(acc(!wn_b, addr_b, wd_b)); ocyc_b.push_back(cyc); end
    if (tp_b === 1'b1) begin tcyc_b.push_back(cyc); tsnap_b.push_back(snap_b); end
    if (irq_b === 1'b1 && !irq_prev_b) rcyc_b.push_back(cyc);
    irq_prev_b = (irq_b === 1'b1);
  end

  // Reference model: expected access stream and tick count per instance.
  logic [19:0] exp_a[$], exp_b[$];
  int          exp_tc_a = 0, exp_tc_b = 0;
  task automatic model_service_a();
    exp_a.push_back(acc(1'b1, 3'd0, 16'h0)); exp_a.push_back(acc(1'b1, 3'd4, 16'h0));
    exp_a.push_back(acc(1'b0, 3'd4, 16'h0)); exp_a.push_back(acc(1'b0, 3'd5, 16'h0));
    exp_tc_a++;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic clear_a();
    obs_a.delete(); ocyc_a.delete(); tcyc_a.delete(); rcyc_a.delete(); tsnap_a.delete(); exp_a.delete();
  endtask
  task automatic pulse_tmo_a();
    tmo_a = 1'b1; step(1); tmo_a = 1'b0;
  endtask
  task automatic wait_tick_a(input int n, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (tcyc_a.size() >= n) break;
    end
  endtask
  task automatic wait_rd_a(input logic [2:0] a, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (cs_a === 1'b1 && wn_a === 1'b1 && addr_a === a) break;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    step(3);
    checks++; if (cs_a !== 1'b0 || wn_a !== 1'b1) begin errors++; $display("FAIL reset_strobes: cs=%b wn=%b want 0/1", cs_a, wn_a); end
    checks++; if (addr_a !== 3'd0 || wd_a !== 16'h0) begin errors++; $display("FAIL reset_addr_data: addr=%0d wd=%h want 0/0", addr_a, wd_a); end
    checks++; if (tc_a !== 32'h0 || tp_a !== 1'b0) begin errors++; $display("FAIL reset_tick: tc=%0d tp=%b want 0/0", tc_a, tp_a); end
    checks++; if (snap_a !== 32'h0 || run_a !== 1'b0 || ovr_a !== 1'b0) begin errors++; $display("FAIL reset_status: snap=%h run=%b ovr=%b want 0", snap_a, run_a, ovr_a); end
    checks++;
    if ({cs_b, wn_b, addr_b, wd_b, tc_b, snap_b, tp_b, run_b, ovr_b} !== {1'b0, 1'b1, 3'd0, 16'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL reset_b: cs=%b wn=%b addr=%0d tc=%0d snap=%h run=%b want idle", cs_b, wn_b, addr_b, tc_b, snap_b, run_b);
    end
    reset_n = 1'b1;
    step(4);
    checks++; if (obs_a.size() !== 0) begin errors++; $display("FAIL idle_quiet: got %0d accesses want 0", obs_a.size()); end
  endtask

  task automatic test_config();
    int c0;
    clear_a();
    obs_b.delete(); ocyc_b.delete();
    step(1);
    en_a = 1'b1; en_b = 1'b1; c0 = cyc;
    exp_a.push_back(acc(1'b1, 3'd1, 16'h0007));
    step(20);
    checks++; if (obs_a.size() !== 1) begin errors++; $display("FAIL cfg_count: got %0d accesses want 1", obs_a.size()); end
    checks++; if (obs_a.size() < 1 || obs_a[0] !== exp_a[0]) begin errors++; $display("FAIL cfg_write: got %h want %h", obs_a.size() ? obs_a[0] : 20'h0, exp_a[0]); end
    checks++; if (ocyc_a.size() < 1 || ocyc_a[0] !== c0 + 1) begin errors++; $display("FAIL cfg_timing: got cycle %0d want %0d", ocyc_a.size() ? ocyc_a[0] : -1, c0 + 1); end
    checks++; if (run_a !== 1'b1 || run_b !== 1'b1) begin errors++; $display("FAIL cfg_running: got %b/%b want 1/1", run_a, run_b); end
    checks++; if (obs_b.size() !== 1 || obs_b[0] !== acc(1'b1, 3'd1, 16'h0007)) begin errors++; $display("FAIL cfg_b: got %0d accesses want one write 0007", obs_b.size()); end
    clear_a();
  endtask

  task automatic test_service();
    clear_a();
    lo_a = 16'h869F; hi_a = 16'h0001;
    pulse_tmo_a();
    model_service_a();
    wait_tick_a(1, 60);
    step(5);
    for (int i = 0; i < exp_a.size(); i++) begin
      checks++;
      if (i >= obs_a.size() || obs_a[i] !== exp_a[i]) begin errors++; $display("FAIL svc_seq[%0d]: got %h want %h", i, (i < obs_a.size()) ? obs_a[i] : 20'hx, exp_a[i]); end
    end
    checks++; if (snap_a !== 32'h0001869F) begin errors++; $display("FAIL svc_snapshot: got %h want 0001869f", snap_a); end
    checks++; if (tc_a !== 32'(exp_tc_a)) begin errors++; $display("FAIL svc_tick_count: got %0d want %0d", tc_a, exp_tc_a); end
    checks++; if (tcyc_a.size() !== 1) begin errors++; $display("FAIL svc_pulse_width: got %0d pulse clocks want 1", tcyc_a.size()); end
    checks++; if (ocyc_a.size() < 1 || rcyc_a.size() < 1 || ocyc_a[0] !== rcyc_a[0] + 1) begin errors++; $display("FAIL svc_irq_latency: CLR at %0d, irq at %0d, want 1 apart", ocyc_a.size() ? ocyc_a[0] : -1, rcyc_a.size() ? rcyc_a[0] : -1); end
    checks++; if (tcyc_a.size() < 1 || ocyc_a.size() < 1 || tcyc_a[0] - (ocyc_a[0] - 1) !== 5 + 2 * RL_A) begin errors++; $display("FAIL svc_latency: got %0d clocks want %0d", (tcyc_a.size() && ocyc_a.size()) ? tcyc_a[0] - ocyc_a[0] + 1 : -1, 5 + 2 * RL_A); end
  endtask

  task automatic test_latency3();
    obs_b.delete(); ocyc_b.delete(); tcyc_b.delete(); rcyc_b.delete(); tsnap_b.delete(); exp_b.delete();
    lo_b = 16'h869F; hi_b = 16'h0001;
    tmo_b = 1'b1; step(1); tmo_b = 1'b0;
    exp_b.push_back(acc(1'b1, 3'd0, 16'h0)); exp_b.push_back(acc(1'b1, 3'd4, 16'h0));
    exp_b.push_back(acc(1'b0, 3'd4, 16'h0)); exp_b.push_back(acc(1'b0, 3'd5, 16'h0));
    exp_tc_b++;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (tcyc_b.size() >= 1) break;
    end
    step(5);
    for (int i = 0; i < exp_b.size(); i++) begin
      checks++;
      if (i >= obs_b.size() || obs_b[i] !== exp_b[i]) begin errors++; $display("FAIL rl3_seq[%0d]: got %h want %h", i, (i < obs_b.size()) ? obs_b[i] : 20'hx, exp_b[i]); end
    end
    checks++; if (snap_b !== 32'h0001869F || tc_b !== 32'(exp_tc_b)) begin errors++; $display("FAIL rl3_result: snap=%h tc=%0d want 0001869f/%0d", snap_b, tc_b, exp_tc_b); end
    checks++; if (tcyc_b.size() !== 1) begin errors++; $display("FAIL rl3_pulse_width: got %0d want 1", tcyc_b.size()); end
    checks++; if (tcyc_b.size() < 1 || ocyc_b.size() < 1 || tcyc_b[0] - (ocyc_b[0] - 1) !== 5 + 2 * RL_B) begin errors++; $display("FAIL rl3_latency: got %0d clocks want %0d", (tcyc_b.size() && ocyc_b.size()) ? tcyc_b[0] - ocyc_b[0] + 1 : -1, 5 + 2 * RL_B); end
  endtask

  task automatic test_random_services();
    logic [15:0] lo, hi;
    for (int n = 0; n < 10; n++) begin
      lo = 16'($urandom); hi = 16'($urandom);
      lo_a = lo; hi_a = hi;
      step($urandom_range(1, 6));
      clear_a();
      pulse_tmo_a();
      model_service_a();
      wait_tick_a(1, 60);
      step(3);
      checks++; if (obs_a.size() !== 4) begin errors++; $display("FAIL rnd%0d_count: got %0d accesses want 4", n, obs_a.size()); end
      for (int i = 0; i < exp_a.size() && i < obs_a.size(); i++) begin
        checks++;
        if (obs_a[i] !== exp_a[i]) begin errors++; $display("FAIL rnd%0d_seq[%0d]: got %h want %h", n, i, obs_a[i], exp_a[i]); end
      end
      checks++; if (snap_a !== {hi, lo}) begin errors++; $display("FAIL rnd%0d_snapshot: got %h want %h", n, snap_a, {hi, lo}); end
      checks++; if (tsnap_a.size() < 1 || tsnap_a[0] !== {hi, lo}) begin errors++; $display("FAIL rnd%0d_coherent: got %h at pulse want %h", n, tsnap_a.size() ? tsnap_a[0] : 32'hx, {hi, lo}); end
      checks++; if (tc_a !== 32'(exp_tc_a)) begin errors++; $display("FAIL rnd%0d_tick_count: got %0d want %0d", n, tc_a, exp_tc_a); end
      checks++; if (tcyc_a.size() < 1 || ocyc_a.size() < 1 || tcyc_a[0] - ocyc_a[0] !== 4 + 2 * RL_A) begin errors++; $display("FAIL rnd%0d_latency: pulse/CLR spacing wrong, want %0d", n, 4 + 2 * RL_A); end
    end
  endtask

  task automatic test_overrun();
    clear_a();
    checks++; if (ovr_a !== 1'b0) begin errors++; $display("FAIL ovr_initial: got %b want 0", ovr_a); end
    lo_a = 16'h1234; hi_a = 16'h0001;
    pulse_tmo_a();
    model_service_a(); model_service_a();
    wait_rd_a(3'd4, 40);
    pulse_tmo_a();
    wait_tick_a(2, 80);
    step(10);
    checks++; if (ovr_a !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got %b want 1", ovr_a); end
    checks++; if (tc_a !== 32'(exp_tc_a)) begin errors++; $display("FAIL ovr_tick_count: got %0d want %0d", tc_a, exp_tc_a); end
    checks++; if (obs_a.size() !== exp_a.size()) begin errors++; $display("FAIL ovr_count: got %0d accesses want %0d", obs_a.size(), exp_a.size()); end
    for (int i = 0; i < exp_a.size() && i < obs_a.size(); i++) begin
      checks++;
      if (obs_a[i] !== exp_a[i]) begin errors++; $display("FAIL ovr_seq[%0d]: got %h want %h", i, obs_a[i], exp_a[i]); end
    end
    checks++; if (ocyc_a.size() < 5 || tcyc_a.size() < 1 || ocyc_a[4] !== tcyc_a[0] + 2) begin errors++; $display("FAIL ovr_reservice: second CLR not 2 clocks after first pulse"); end
  endtask

  task automatic test_stop();
    clear_a();
    lo_a = 16'($urandom); hi_a = 16'($urandom);
    pulse_tmo_a();
    model_service_a();
    exp_a.push_back(acc(1'b1, 3'd1, 16'h0008));
    wait_rd_a(3'd5, 40);
    en_a = 1'b0;
    wait_tick_a(1, 40);
    step(6);
    checks++; if (run_a !== 1'b0) begin errors++; $display("FAIL stop_running: got %b want 0", run_a); end
    pulse_tmo_a();
    step(15);
    checks++; if (obs_a.size() !== exp_a.size()) begin errors++; $display("FAIL stop_count: got %0d accesses want %0d", obs_a.size(), exp_a.size()); end
    for (int i = 0; i < exp_a.size() && i < obs_a.size(); i++) begin
      checks++;
      if (obs_a[i] !== exp_a[i]) begin errors++; $display("FAIL stop_seq[%0d]: got %h want %h", i, obs_a[i], exp_a[i]); end
    end
    checks++; if (tc_a !== 32'(exp_tc_a) || snap_a !== {hi_a, lo_a}) begin errors++; $display("FAIL stop_service: tc=%0d snap=%h want %0d/%h", tc_a, snap_a, exp_tc_a, {hi_a, lo_a}); end
    checks++; if (ocyc_a.size() < 5 || tcyc_a.size() < 1 || ocyc_a[4] !== tcyc_a[0] + 2) begin errors++; $display("FAIL stop_timing: stop write not 2 clocks after pulse"); end
  endtask

  task automatic test_reset_mid();
    int c0;
    clear_a();
    en_a = 1'b1;
    wait_rd_a(3'd4, 40);
    checks++; if (obs_a.size() < 1 || obs_a[0] !== acc(1'b1, 3'd1, 16'h0007)) begin errors++; $display("FAIL mid_cfg: first access %h want config write", obs_a.size() ? obs_a[0] : 20'hx); end
    step(1);
    reset_n = 1'b0;
    #1;
    checks++; if (cs_a !== 1'b0 || wn_a !== 1'b1 || addr_a !== 3'd0 || wd_a !== 16'h0) begin errors++; $display("FAIL mid_bus: cs=%b wn=%b addr=%0d wd=%h want idle", cs_a, wn_a, addr_a, wd_a); end
    checks++; if (tc_a !== 32'h0 || snap_a !== 32'h0 || run_a !== 1'b0 || ovr_a !== 1'b0 || tp_a !== 1'b0) begin errors++; $display("FAIL mid_status: tc=%0d snap=%h run=%b ovr=%b want 0", tc_a, snap_a, run_a, ovr_a); end
    step(3);
    clear_a();
    exp_tc_a = 0;
    reset_n = 1'b1; c0 = cyc;
    step(20);
    checks++; if (obs_a.size() !== 1 || obs_a[0] !== acc(1'b1, 3'd1, 16'h0007)) begin errors++; $display("FAIL mid_recfg: got %0d accesses, want one config write", obs_a.size()); end
    checks++; if (ocyc_a.size() < 1 || ocyc_a[0] !== c0 + 1) begin errors++; $display("FAIL mid_recfg_timing: got %0d want %0d", ocyc_a.size() ? ocyc_a[0] : -1, c0 + 1); end
    checks++; if (tc_a !== 32'(exp_tc_a) || snap_a !== 32'h0 || tcyc_a.size() !== 0) begin errors++; $display("FAIL mid_no_tick: tc=%0d snap=%h pulses=%0d want 0", tc_a, snap_a, tcyc_a.size()); end
  endtask

  initial begin
    test_reset();
    test_config();
    test_service();
    test_latency3();
    test_random_services();
    test_overrun();
    test_stop();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
